// File: rtl/smg_pkg.sv
// Shared constants for the seven-segment scan controller: segment bit
// positions and the active-high hex glyph table (bit0=a .. bit6=g).
package smg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/smg_hex_decoder.sv
// Combinational hex nibble to active-high 7-segment pattern lookup.
module smg_hex_decoder
    import smg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/smg_scan_controller.sv
// Multiplexed seven-segment scan controller: frame-coherent snapshot of the
// digit inputs, leading-zero blanking and registered, polarity-adjusted outputs.
module smg_scan_controller
    import smg_pkg::*;
#(
    parameter int DIGITS         = 3,
    parameter int SCAN_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Enable,
    input  logic [4*DIGITS-1:0]   Number_Sig,
    input  logic [DIGITS-1:0]     DP_Sig,
    input  logic                  Blank_LZ,
    output logic [7:0]            SMG_Data,
    output logic [DIGITS-1:0]     Scan_Sig,
    output logic                  Frame_Done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [7:0]        SEG_OFF  = {8{SEG_ACTIVE_LOW != 0}};
    localparam logic [DIGITS-1:0] SEL_OFF  = {DIGITS{SEL_ACTIVE_LOW != 0}};

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("smg_scan_controller: DIGITS must be in 1..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("smg_scan_controller: SCAN_DIV must be >= 2");
    end

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] snap_num;
    logic [DIGITS-1:0]   snap_dp;
    logic                snap_blz;
    logic                load_pend;

    logic                running;
    logic                tick;
    logic                frame_end;
    logic                load;
    logic [3:0]          digit_nibble;
    logic [6:0]          pattern;
    logic [DIGITS-1:0]   lz;
    logic                above_zero;
    logic                blank;
    logic [7:0]          seg_word;
    logic [DIGITS-1:0]   sel_word;

    // The first enabled edge after reset only captures the snapshot; the
    // counter starts running on the edge after, so digit 0 gets a full slot.
    always_comb begin
        running   = Enable && !load_pend;
        tick      = running && (cnt == CNT_LAST);
        frame_end = tick && (idx == IDX_LAST);
        load      = Enable && (load_pend || frame_end);
    end

    smg_hex_decoder u_hex_decoder (
        .nibble  (digit_nibble),
        .pattern (pattern)
    );

    // lz[i] is set when nibble i and every nibble above it are zero.
    always_comb begin
        lz         = '0;
        above_zero = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            above_zero = above_zero && (snap_num[4*(DIGITS-1-k) +: 4] == 4'h0);
            lz[DIGITS-1-k] = above_zero;
        end
    end

    always_comb begin
        digit_nibble     = snap_num[idx*4 +: 4];
        blank            = snap_blz && (idx != '0) && lz[idx];
        seg_word         = '0;
        seg_word[6:0]    = blank ? 7'h00 : pattern;
        seg_word[SEG_DP] = snap_dp[idx];
        if (SEG_ACTIVE_LOW != 0) seg_word = ~seg_word;
        sel_word         = '0;
        sel_word[idx]    = 1'b1;
        if (SEL_ACTIVE_LOW != 0) sel_word = ~sel_word;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt        <= '0;
            idx        <= '0;
            snap_num   <= '0;
            snap_dp    <= '0;
            snap_blz   <= 1'b0;
            load_pend  <= 1'b1;
            Frame_Done <= 1'b0;
            SMG_Data   <= SEG_OFF;
            Scan_Sig   <= SEL_OFF;
        end else begin
            Frame_Done <= frame_end;
            if (load) begin
                snap_num  <= Number_Sig;
                snap_dp   <= DP_Sig;
                snap_blz  <= Blank_LZ;
                load_pend <= 1'b0;
            end
            if (running) begin
                if (tick) begin
                    cnt <= '0;
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            SMG_Data <= running ? seg_word : SEG_OFF;
            Scan_Sig <= running ? sel_word : SEL_OFF;
        end
    end

endmodule

// File: tb/tb_smg_scan_controller.sv
// Self-checking bench for smg_scan_controller (DIGITS=3, SCAN_DIV=4, active-low).
module tb_smg_scan_controller;

    localparam int DIGITS   = 3;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic        CLK;
    logic        RST;
    logic        Enable;
    logic [11:0] Number_Sig;
    logic [2:0]  DP_Sig;
    logic        Blank_LZ;
    logic [7:0]  SMG_Data;
    logic [2:0]  Scan_Sig;
    logic        Frame_Done;

    int n_total = 0;
    int n_bad   = 0;

    smg_scan_controller #(
        .DIGITS         (DIGITS),
        .SCAN_DIV       (SCAN_DIV),
        .SEG_ACTIVE_LOW (1),
        .SEL_ACTIVE_LOW (1)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Enable     (Enable),
        .Number_Sig (Number_Sig),
        .DP_Sig     (DP_Sig),
        .Blank_LZ   (Blank_LZ),
        .SMG_Data   (SMG_Data),
        .Scan_Sig   (Scan_Sig),
        .Frame_Done (Frame_Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference glyphs, gfedcba, active-high.
    logic [6:0] hex7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Model: frame position counted in enabled display cycles.
    bit          started = 1'b0;
    int unsigned pos     = 0;
    logic [11:0] m_num   = '0;
    logic [2:0]  m_dp    = '0;
    logic        m_blz   = 1'b0;
    logic [7:0]  exp_seg;
    logic [2:0]  exp_sel;
    logic        exp_fd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] render_seg(int unsigned d);
        logic [11:0] upper;
        logic [6:0]  pat;
        upper = m_num >> (4 * d);
        pat   = hex7[upper[3:0]];
        if (m_blz && d > 0 && upper == 12'h000) pat = 7'h00;
        return ~{m_dp[d], pat};
    endfunction

    task automatic snapshot();
        m_num = Number_Sig;
        m_dp  = DP_Sig;
        m_blz = Blank_LZ;
    endtask

    task automatic model_edge();
        int unsigned d;
        logic [2:0]  one;
        one    = 3'b001;
        exp_fd = 1'b0;
        if (RST) begin
            started = 1'b0;
            pos     = 0;
            m_num   = '0;
            m_dp    = '0;
            m_blz   = 1'b0;
            exp_seg = 8'hFF;
            exp_sel = 3'b111;
        end else if (!Enable) begin
            exp_seg = 8'hFF;
            exp_sel = 3'b111;
        end else if (!started) begin
            started = 1'b1;
            pos     = 0;
            snapshot();
            exp_seg = 8'hFF;
            exp_sel = 3'b111;
        end else begin
            d       = pos / SCAN_DIV;
            exp_seg = render_seg(d);
            exp_sel = ~(one << d);
            pos++;
            if (pos == FRAME) begin
                exp_fd = 1'b1;
                pos    = 0;
                snapshot();
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge CLK);
        #1;
        check("seg", SMG_Data, exp_seg);
        check("sel", Scan_Sig, exp_sel);
        check("frame_done", Frame_Done, exp_fd);
    endtask

    initial begin
        int fd_cnt;
        RST        = 1'b1;
        Enable     = 1'b0;
        Number_Sig = 12'h123;
        DP_Sig     = 3'b000;
        Blank_LZ   = 1'b0;

        cycle();
        cycle();
        check("rst_seg", SMG_Data, 8'hFF);
        check("rst_sel", Scan_Sig, 3'b111);
        check("rst_fd", Frame_Done, 1'b0);
        RST    = 1'b0;
        Enable = 1'b1;

        // Scan order over two frames.
        cycle();
        fd_cnt = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            cycle();
            if (Frame_Done) fd_cnt++;
            if (k == 0) begin
                check("order_d0_seg", SMG_Data, 8'hB0);
                check("order_d0_sel", Scan_Sig, 3'b110);
            end
            if (k == 4) begin
                check("order_d1_seg", SMG_Data, 8'hA4);
                check("order_d1_sel", Scan_Sig, 3'b101);
            end
            if (k == 8) begin
                check("order_d2_seg", SMG_Data, 8'hF9);
                check("order_d2_sel", Scan_Sig, 3'b011);
            end
        end
        check("frame_done_count", fd_cnt, 2);

        // Input change mid-frame must not tear the display.
        repeat (5) cycle();
        Number_Sig = 12'h456;
        cycle();
        check("tear_d1_seg", SMG_Data, 8'hA4);
        repeat (6) cycle();
        cycle();
        check("tear_next_d0_seg", SMG_Data, 8'h82);

        // Leading-zero blanking.
        Number_Sig = 12'h007;
        Blank_LZ   = 1'b1;
        repeat (11) cycle();
        cycle();
        check("blz_d0_seg", SMG_Data, 8'hF8);
        repeat (3) cycle();
        cycle();
        check("blz_d1_seg", SMG_Data, 8'hFF);
        check("blz_d1_sel", Scan_Sig, 3'b101);
        repeat (3) cycle();
        cycle();
        check("blz_d2_seg", SMG_Data, 8'hFF);
        Number_Sig = 12'h000;
        repeat (3) cycle();
        cycle();
        check("blz_zero_d0_seg", SMG_Data, 8'hC0);

        // Enable gap mid-digit, then decimal point on digit 1.
        Number_Sig = 12'h123;
        DP_Sig     = 3'b010;
        Blank_LZ   = 1'b0;
        repeat (11) cycle();
        cycle();
        cycle();
        Enable = 1'b0;
        repeat (5) cycle();
        check("gap_seg_off", SMG_Data, 8'hFF);
        check("gap_sel_off", Scan_Sig, 3'b111);
        Enable = 1'b1;
        cycle();
        check("resume_d0_seg", SMG_Data, 8'hB0);
        cycle();
        cycle();
        check("dp_d1_seg", SMG_Data, 8'h24);
        check("dp_d1_sel", Scan_Sig, 3'b101);

        // Reset while digit 2 is lit.
        repeat (4) cycle();
        check("pre_rst_sel", Scan_Sig, 3'b011);
        RST = 1'b1;
        cycle();
        RST        = 1'b0;
        Number_Sig = 12'h456;
        cycle();
        check("post_rst_load_seg", SMG_Data, 8'hFF);
        cycle();
        check("post_rst_d0_seg", SMG_Data, 8'h82);
        check("post_rst_d0_sel", Scan_Sig, 3'b110);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            RST    = ($urandom_range(0, 199) == 0);
            Enable = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < DIGITS; j++)
                    Number_Sig[4*j +: 4] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                DP_Sig   = 3'($urandom_range(0, 7));
                Blank_LZ = 1'($urandom_range(0, 1));
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
